dec6_rr_arbiter: RTL

Round-robin arbiter that shares a single 3-to-6 one-hot select path among six requesters. Each requester raises a request line. The arbiter grants one requester at a time and drives a 3-bit index plus an active-high enable, the same encoding consumed by the team's active-high-enable 3-to-6 decoder. It also drives the already-decoded 6-bit one-hot grant. Grants are held while the owner keeps requesting, up to a programmable maximum tenure, after which the grant is forcibly revoked so that other requesters are not starved.

---
 rtl/dec6_rr_arbiter_if.sv | 37 +++
 rtl/dec6_rr_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/dec6_rr_arbiter_if.sv
// Request/grant bundle between six requesters and the round-robin arbiter.
//
// Handshake: a requester asks by holding its req bit high and keeps it high
// for as long as it wants ownership. A grant is valid only while gnt_en=1.
// gnt and gnt_idx name the owner. The owner gives the grant back by dropping
// its req bit, and the release takes effect at the next clock edge. The
// arbiter may also revoke the grant on its own; it flags that with a one-cycle
// timeout pulse in the first cycle that has gnt_en=0. gnt_idx holds its last
// value while gnt_en=0, so it must always be qualified with gnt_en.
interface dec6_rr_arbiter_if;
  logic [5:0] req;
  logic       gnt_en;
  logic [2:0] gnt_idx;
  logic [5:0] gnt;
  logic       busy;
  logic       timeout;

  // Arbiter side: samples requests, drives the grant path.
  modport master (
    input  req,
    output gnt_en,
    output gnt_idx,
    output gnt,
    output busy,
    output timeout
  );

  // Requester side: drives requests, observes the grant path.
  modport slave (
    output req,
    input  gnt_en,
    input  gnt_idx,
    input  gnt,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/dec6_rr_arbiter.sv
// Round-robin arbiter for six requesters with a bounded grant tenure.
// It drives an index/enable pair for a 3-to-6 decoder and also the
// pre-decoded one-hot grant. Every output is registered. There is always one
// dead cycle between grants, and re-arbitration happens only in IDLE.
module dec6_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  dec6_rr_arbiter_if.master bus,
  output logic              o_dbg_state,
  output logic [2:0]        o_dbg_ptr
);

  // Hold counter width. It is at least 1 bit, including the unlimited case
  // (MAX_HOLD=0).
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [2:0]      r_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_gnt_en;
  logic [2:0]      r_gnt_idx;
  logic [5:0]      r_gnt;
  logic            r_timeout;

  logic            w_found;
  logic [2:0]      w_sel_idx;
  logic            w_own_req;
  logic            w_at_limit;
  logic [2:0]      w_next_ptr;

  // Circular priority search: the first request at r_ptr, r_ptr+1, ... mod 6.
  always_comb begin
    logic [3:0] v_cand;
    w_found   = 1'b0;
    w_sel_idx = 3'd0;
    v_cand    = 4'd0;
    for (int k = 0; k < 6; k++) begin
      v_cand = {1'b0, r_ptr} + 4'(k);
      if (v_cand >= 4'd6) begin
        v_cand = v_cand - 4'd6;
      end
      if (!w_found && bus.req[v_cand[2:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = v_cand[2:0];
      end
    end
  end

  // In GRANT, r_gnt is the owner's one-hot code, so masking req with it
  // gives the owner's own request line.
  assign w_own_req  = |(bus.req & r_gnt);
  assign w_at_limit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
  assign w_next_ptr = (r_gnt_idx == 3'd5) ? 3'd0 : r_gnt_idx + 3'd1;

  // Arbitration FSM. All outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 3'd0;
      r_hold_cnt <= '0;
      r_gnt_en   <= 1'b0;
      r_gnt_idx  <= 3'd0;
      r_gnt      <= 6'b000000;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            r_gnt_en   <= 1'b1;
            r_gnt_idx  <= w_sel_idx;
            r_gnt      <= 6'd1 << w_sel_idx;
            r_hold_cnt <= '0;
          end
        end
        S_GRANT: begin
          // A voluntary release always wins over a revoke that is due on
          // the same edge. timeout fires only if the owner still wants the grant.
          if (!w_own_req || w_at_limit) begin
            r_state   <= S_IDLE;
            r_gnt_en  <= 1'b0;
            r_gnt     <= 6'b000000;
            r_ptr     <= w_next_ptr;
            r_timeout <= w_own_req;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_en  = r_gnt_en;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_gnt_en;
  assign bus.timeout = r_timeout;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule
